// File: rtl/bcd_seg_display.sv
// 8-bit value to 3-digit BCD (double-dabble) or hex nibbles, shown on a
// scanned 3-digit seven-segment display with leading-zero blanking.
//
// state   | meaning
// IDLE    | waiting for a load strobe
// CONVERT | one shift-add-3 step per cycle, 8 steps
// DONE    | publish result, then start pending/new request or idle
module bcd_seg_display #(
    parameter int REFRESH_DIV  = 50000,
    parameter bit COMMON_ANODE = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [7:0]  data_in,
    input  logic        hex_mode,
    output logic        busy,
    output logic [11:0] bcd_out,
    output logic        bcd_valid,
    output logic [6:0]  seg,
    output logic [2:0]  an
);

    localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [19:0] sr_q, sr_d;
    logic [2:0]  step_q, step_d;
    logic        mode_q, mode_d;
    logic        pend_v_q, pend_v_d;
    logic [7:0]  pend_data_q, pend_data_d;
    logic        pend_hex_q, pend_hex_d;
    logic [11:0] bcd_q, bcd_d;
    logic        valid_q, valid_d;
    logic [11:0] disp_q, disp_d;
    logic        disp_hex_q, disp_hex_d;

    logic [CNT_W-1:0] refresh_q;
    logic [1:0]       idx_q;

    logic       go;
    logic [7:0] go_data;
    logic       go_hex;

    function automatic logic [19:0] dd_step(input logic [19:0] v);
        logic [19:0] t;
        t = v;
        if (t[11:8]  >= 4'd5) t[11:8]  = t[11:8]  + 4'd3;
        if (t[15:12] >= 4'd5) t[15:12] = t[15:12] + 4'd3;
        if (t[19:16] >= 4'd5) t[19:16] = t[19:16] + 4'd3;
        return {t[18:0], 1'b0};
    endfunction

    function automatic logic [6:0] seg_pat(input logic [3:0] d);
        logic [6:0] p;
        case (d)
            4'h0: p = 7'b0111111;
            4'h1: p = 7'b0000110;
            4'h2: p = 7'b1011011;
            4'h3: p = 7'b1001111;
            4'h4: p = 7'b1100110;
            4'h5: p = 7'b1101101;
            4'h6: p = 7'b1111101;
            4'h7: p = 7'b0000111;
            4'h8: p = 7'b1111111;
            4'h9: p = 7'b1101111;
            4'hA: p = 7'b1110111;
            4'hB: p = 7'b1111100;
            4'hC: p = 7'b0111001;
            4'hD: p = 7'b1011110;
            4'hE: p = 7'b1111001;
            default: p = 7'b1110001;
        endcase
        return p;
    endfunction

    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        step_d      = step_q;
        mode_d      = mode_q;
        pend_v_d    = pend_v_q;
        pend_data_d = pend_data_q;
        pend_hex_d  = pend_hex_q;
        bcd_d       = bcd_q;
        valid_d     = 1'b0;
        disp_d      = disp_q;
        disp_hex_d  = disp_hex_q;
        go          = 1'b0;
        go_data     = data_in;
        go_hex      = hex_mode;

        case (state_q)
            IDLE: begin
                go = load;
            end
            CONVERT: begin
                sr_d   = dd_step(sr_q);
                step_d = step_q + 3'd1;
                if (step_q == 3'd7) state_d = DONE;
                if (load) begin
                    pend_v_d    = 1'b1;
                    pend_data_d = data_in;
                    pend_hex_d  = hex_mode;
                end
            end
            DONE: begin
                bcd_d      = sr_q[19:8];
                valid_d    = 1'b1;
                disp_d     = sr_q[19:8];
                disp_hex_d = mode_q;
                pend_v_d   = 1'b0;
                state_d    = IDLE;
                // A fresh strobe in this cycle supersedes the buffered one.
                if (load) begin
                    go = 1'b1;
                end else if (pend_v_q) begin
                    go      = 1'b1;
                    go_data = pend_data_q;
                    go_hex  = pend_hex_q;
                end
            end
            default: state_d = IDLE;
        endcase

        if (go) begin
            mode_d = go_hex;
            step_d = 3'd0;
            if (go_hex) begin
                state_d = DONE;
                sr_d    = {4'h0, go_data, 8'h00};
            end else begin
                state_d = CONVERT;
                sr_d    = {12'd0, go_data};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sr_q        <= '0;
            step_q      <= '0;
            mode_q      <= 1'b0;
            pend_v_q    <= 1'b0;
            pend_data_q <= '0;
            pend_hex_q  <= 1'b0;
            bcd_q       <= '0;
            valid_q     <= 1'b0;
            disp_q      <= '0;
            disp_hex_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            step_q      <= step_d;
            mode_q      <= mode_d;
            pend_v_q    <= pend_v_d;
            pend_data_q <= pend_data_d;
            pend_hex_q  <= pend_hex_d;
            bcd_q       <= bcd_d;
            valid_q     <= valid_d;
            disp_q      <= disp_d;
            disp_hex_q  <= disp_hex_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            refresh_q <= '0;
            idx_q     <= 2'd0;
        end else if (refresh_q == CNT_MAX) begin
            refresh_q <= '0;
            idx_q     <= (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
        end else begin
            refresh_q <= refresh_q + 1'b1;
        end
    end

    logic       blank_h, blank_t, blank;
    logic [3:0] digit;
    logic [6:0] seg_hi;
    logic [2:0] an_hi;

    always_comb begin
        blank_h = disp_hex_q || (disp_q[11:8] == 4'd0);
        blank_t = !disp_hex_q && (disp_q[11:8] == 4'd0) && (disp_q[7:4] == 4'd0);
        digit   = disp_q[3:0];
        blank   = 1'b0;
        an_hi   = 3'b001;
        case (idx_q)
            2'd0: begin digit = disp_q[3:0];  blank = 1'b0;    an_hi = 3'b001; end
            2'd1: begin digit = disp_q[7:4];  blank = blank_t; an_hi = 3'b010; end
            2'd2: begin digit = disp_q[11:8]; blank = blank_h; an_hi = 3'b100; end
            default: begin blank = 1'b1; an_hi = 3'b000; end
        endcase
        seg_hi = blank ? 7'b0000000 : seg_pat(digit);
    end

    assign seg       = COMMON_ANODE ? ~seg_hi : seg_hi;
    assign an        = COMMON_ANODE ? ~an_hi : an_hi;
    assign busy      = (state_q != IDLE);
    assign bcd_out   = bcd_q;
    assign bcd_valid = valid_q;

endmodule

// File: doc/bcd_seg_display.md
# bcd_seg_display

Display back end for the 8-bit register datapath. It accepts the 8-bit value being written into the register file (`data_in` plus a one-cycle `load` strobe) and converts it to three BCD digits with a sequential shift-add-3 (double-dabble) engine; a hex mode passes the two nibbles through instead. It then time-multiplexes the digits onto a 3-digit seven-segment display with leading-zero blanking. One pending request is buffered while a conversion is in flight.

## Interface
Parameters:
- `REFRESH_DIV`, default 50000: clock cycles each digit stays lit; legal range ≥ 2.
- `COMMON_ANODE`, default 1: 1 makes `seg` and `an` active-low; 0 makes them active-high.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `load`  in  1  request strobe; `data_in` and `hex_mode` are sampled on the same edge.
- `data_in`  in  8  value to display.
- `hex_mode`  in  1  1 selects nibble display, 0 selects decimal conversion.
- `busy`  out  1  high whenever the FSM is not IDLE.
- `bcd_out`  out  12  {hundreds, tens, ones}; registered.
- `bcd_valid`  out  1  one-cycle pulse when `bcd_out` updates.
- `seg`  out  7  {g,f,e,d,c,b,a}.
- `an`  out  3  digit enables, one-hot; an[0] is ones, an[2] is hundreds.

## Operation
- FSM states are IDLE, CONVERT and DONE.
- **IDLE + load:**
  - With `hex_mode`=0, load a 20-bit shift register with {12'd0, data_in}, clear the 3-bit step counter and go to CONVERT.
  - With `hex_mode`=1, go directly to DONE with result {4'h0, data_in[7:4], data_in[3:0]}.
- **CONVERT, one step per cycle:**
  - For each BCD digit field of the shift register, add 3 if the field is ≥ 5.
  - Then shift the whole 20-bit register left by 1.
  - After the 8th step, go to DONE.
  - 4-bit digit fields; the add-3 never overflows because 9+3 < 16.
- **DONE, one cycle:**
  - Register the result into `bcd_out` and into the display digit registers, and latch the mode into the display.
  - Assert `bcd_valid` for the following cycle.
  - Next state: the pending request if one exists, else IDLE.
- **Pending buffer:** one entry holding data, hex flag and pend flag.
  - A `load` while busy (CONVERT or DONE) is written into the buffer; the newest request overwrites the older one, and the older one is dropped silently.
  - When DONE is left, the buffered request is started exactly as from IDLE and pend is cleared. `busy` stays high through that transition.
  - A `load` in the same DONE cycle is the request that starts; the older pending entry is discarded.
- **Blanking:**
  - Decimal mode: hundreds is blank when it is 0; tens is blank when hundreds=0 and tens=0; ones is always shown.
  - Hex mode: hundreds is always blank; tens and ones are always shown, decoding 0–F including A, b, C, d, E, F.
- **Segment decode:** standard patterns. Digit '0' (active-high) is a–f lit, i.e. 7'b0111111. A blank digit drives all segments off.
- **Scan:**
  - A refresh counter runs from 0 to REFRESH_DIV−1 and wraps.
  - On wrap, the digit index advances 0→1→2→0.
  - `an` is a combinational one-hot decode of the index.
  - `seg` is a combinational decode of the indexed digit register and its blank state.
  - The scan free-runs and is independent of the FSM.

## Timing
- Reset, with `rst_n` low at an edge, forces on that edge:
  - FSM to IDLE; `busy`=0; `bcd_out`=0; `bcd_valid`=0.
  - Pending entry cleared; display registers cleared to 0, decimal mode.
  - Refresh counter and digit index to 0.
- Resulting outputs with COMMON_ANODE=1: `an`=3'b110, `seg`=7'b1000000.
- Reset mid-conversion aborts the conversion with no `bcd_valid`, drops the pending entry and returns the display to "0".
- Decimal latency, with `load` sampled at edge 0:
  - CONVERT steps occur at edges 1–8; DONE is the cycle after edge 8.
  - `bcd_out` updates at edge 9; `bcd_valid` is high from edge 9 to edge 10.
  - `busy` is high from edge 0 to edge 9.
- Hex latency: `load` at edge 0, DONE the following cycle, `bcd_out` at edge 1, `bcd_valid` high from edge 1 to edge 2.
- Back-to-back decimal requests through the pending buffer give a throughput of one result per 9 cycles.
- The display changes on the same edge as `bcd_out`.
- The digit index advances every REFRESH_DIV cycles; the first advance occurs at edge REFRESH_DIV after reset release.

## Test plan
- **Reset:** hold `rst_n`=0 for 2 cycles mid-activity -> `busy`=0, `bcd_out`=12'h000, `an`=3'b110, `seg`=7'b1000000, no `bcd_valid`.
- **Decimal 255:** `load` with `data_in`=8'd255, `hex_mode`=0 -> `busy` high for 9 cycles, single `bcd_valid`, `bcd_out`=12'h255, digits "255".
- **Blanking:**
  - 8'd7 -> `bcd_out`=12'h007, hundreds and tens blank.
  - 8'd105 -> 12'h105, tens shows "0".
  - 8'd0 -> only the ones digit lit as "0".
- **Hex mode:** 8'hA3 -> `bcd_valid` after 1 edge, `bcd_out`=12'h0A3, display " A3", hundreds blank.
- **Pending buffer:** `load` 200, then `load` 10 at edge 3 and `load` 20 at edge 5 -> results 12'h200 then 12'h020, two `bcd_valid` pulses 9 cycles apart, 10 never appears, `busy` continuous for 18 cycles.
- **Scan with REFRESH_DIV=4:**
  - `an` sequence 110→101→011→110, changing every 4 cycles.
  - Assert reset during CONVERT -> `busy`=0 at the next edge, the scan restarts at `an`=110, and no result is produced.
